// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle controller: IDLE -> FETCH -> DECODE -> EXEC per instruction,
// with a fetch handshake, a fetch timeout and a retired-instruction counter.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, undefined opcodes
// raise a sticky illegal flag and halt. When it is not defined, they run as NOP.
module multicycle_ctrl_fsm #(
  parameter int OPC_W         = 4,
  parameter int SELALU_W      = 4,
  parameter int CNT_W         = 16,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                CLB,
  input  logic                run,
  input  logic                mem_ack,
  input  logic [OPC_W-1:0]    Opcode,
  input  logic                Z,
  input  logic                C,
  output logic                mem_req,
  output logic                LoadIR,
  output logic                IncPC,
  output logic                SelPC,
  output logic                LoadPC,
  output logic                LoadReg,
  output logic                LoadAcc,
  output logic [1:0]          SelAcc,
  output logic [SELALU_W-1:0] SelALU,
  output logic [2:0]          state,
  output logic                halted,
  output logic                fetch_err,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;

  // The wait counter only has to reach FETCH_TIMEOUT. A width of 1 is enough when the timeout is 0 or 1.
  localparam int WAIT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic [2:0]       state_reg, state_next;
  logic [OPC_W-1:0] opc_reg;
  logic             z_reg, c_reg;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [CNT_W-1:0] retired_reg;

  logic       opc_defined;
  logic [3:0] opc_lo;
  logic [3:0] sel_alu4;

  assign opc_lo = opc_reg[3:0];

  // An opcode is defined only when all bits above [3:0] are zero. Codes 1001 and 1110 are never defined.
  always_comb begin
    opc_defined = ((opc_reg >> 4) == OPC_W'(0)) && (opc_lo != 4'b1001) && (opc_lo != 4'b1110);
  end

  // Next-state and fetch wait-counter logic.
  always_comb begin
    state_next = state_reg;
    wait_next  = '0;
    case (state_reg)
      S_IDLE: begin
        if (run) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_next = S_DECODE;
        end else begin
          wait_next = wait_reg + 1'b1;
          if ((FETCH_TIMEOUT != 0) && (wait_next == WAIT_W'(FETCH_TIMEOUT)))
            state_next = S_ERR;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (opc_reg == OPC_W'(15) || (TRAP && !opc_defined))
          state_next = S_HALT;
        else
          state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_IDLE;
    endcase
  end

  // Update the state and wait counter. At DECODE, latch the opcode and flags. Count EXEC cycles.
  always_ff @(posedge clk) begin
    if (CLB) begin
      state_reg   <= S_IDLE;
      wait_reg    <= '0;
      opc_reg     <= '0;
      z_reg       <= 1'b0;
      c_reg       <= 1'b0;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      if (state_reg == S_DECODE) begin
        opc_reg <= Opcode;
        z_reg   <= Z;
        c_reg   <= C;
      end
      if (state_reg == S_EXEC) retired_reg <= retired_reg + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_reg;

  // The illegal flag is sticky. It is set when an undefined opcode reaches EXEC and cleared only by reset.
  always_ff @(posedge clk) begin
    if (CLB) illegal_reg <= 1'b0;
    else if (state_reg == S_EXEC && !opc_defined) illegal_reg <= 1'b1;
  end
  assign illegal = illegal_reg;
`else
  assign illegal = 1'b0;
`endif

  // Moore decode of the EXEC strobes from the latched opcode and flags.
  always_comb begin
    IncPC    = 1'b0;
    SelPC    = 1'b0;
    LoadPC   = 1'b0;
    LoadReg  = 1'b0;
    LoadAcc  = 1'b0;
    SelAcc   = 2'b00;
    sel_alu4 = 4'b0000;
    if (state_reg == S_EXEC) begin
      if (!opc_defined) begin
        IncPC = !TRAP;
      end else begin
        case (opc_lo)
          4'b0000: IncPC = 1'b1;
          4'b0001: begin sel_alu4 = 4'b1000; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b0010: begin sel_alu4 = 4'b1100; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b0011: begin sel_alu4 = 4'b0100; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b0100: begin SelAcc = 2'b01; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b0101: begin LoadReg = 1'b1; IncPC = 1'b1; end
          4'b1011: begin sel_alu4 = 4'b0001; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b1100: begin sel_alu4 = 4'b0011; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b1101: begin SelAcc = 2'b10; LoadAcc = 1'b1; IncPC = 1'b1; end
          4'b0110: begin LoadPC = z_reg; SelPC = z_reg; IncPC = !z_reg; end
          4'b0111: begin LoadPC = z_reg; IncPC = !z_reg; end
          4'b1000: begin LoadPC = c_reg; SelPC = c_reg; IncPC = !c_reg; end
          4'b1010: begin LoadPC = c_reg; IncPC = !c_reg; end
          default: ; // 1111 HALT: no strobes
        endcase
      end
    end
  end

  assign SelALU    = SELALU_W'(sel_alu4);
  assign mem_req   = (state_reg == S_FETCH);
  assign LoadIR    = (state_reg == S_FETCH) && mem_ack;
  assign state     = state_reg;
  assign halted    = (state_reg == S_HALT);
  assign fetch_err = (state_reg == S_ERR);
  assign retired   = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm. It uses table vectors, random programs
// checked against an instruction-level model, and hand-written multi-cycle sequences.
module tb_multicycle_ctrl_fsm;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic CLB = 1'b1, run = 1'b0, mem_ack = 1'b0, Z = 1'b0, C = 1'b0;
  logic [5:0] Opcode = '0;

  logic mem_req, LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc, halted, fetch_err, illegal;
  logic [1:0] SelAcc;
  logic [5:0] SelALU;
  logic [2:0] state;
  logic [15:0] retired;

  logic mem_req2, LoadIR2, IncPC2, SelPC2, LoadPC2, LoadReg2, LoadAcc2, halted2, fetch_err2, illegal2;
  logic [1:0] SelAcc2;
  logic [5:0] SelALU2;
  logic [2:0] state2;
  logic [1:0] retired2;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.OPC_W(6), .SELALU_W(6), .CNT_W(16), .FETCH_TIMEOUT(15)) dut (
    .clk(clk), .CLB(CLB), .run(run), .mem_ack(mem_ack), .Opcode(Opcode), .Z(Z), .C(C),
    .mem_req(mem_req), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC), .LoadPC(LoadPC),
    .LoadReg(LoadReg), .LoadAcc(LoadAcc), .SelAcc(SelAcc), .SelALU(SelALU), .state(state),
    .halted(halted), .fetch_err(fetch_err), .illegal(illegal), .retired(retired));

  // Narrow counter and no timeout: used for wrap-around and the no-timeout case.
  multicycle_ctrl_fsm #(.OPC_W(6), .SELALU_W(6), .CNT_W(2), .FETCH_TIMEOUT(0)) dut2 (
    .clk(clk), .CLB(CLB), .run(run), .mem_ack(mem_ack), .Opcode(Opcode), .Z(Z), .C(C),
    .mem_req(mem_req2), .LoadIR(LoadIR2), .IncPC(IncPC2), .SelPC(SelPC2), .LoadPC(LoadPC2),
    .LoadReg(LoadReg2), .LoadAcc(LoadAcc2), .SelAcc(SelAcc2), .SelALU(SelALU2), .state(state2),
    .halted(halted2), .fetch_err(fetch_err2), .illegal(illegal2), .retired(retired2));

  // Strobe word layout: {IncPC, LoadPC, SelPC, LoadReg, LoadAcc, SelAcc[1:0], SelALU[3:0]}
  logic [10:0] dut_word;
  assign dut_word = {IncPC, LoadPC, SelPC, LoadReg, LoadAcc, SelAcc, SelALU[3:0]};

  int n_cmp = 0, n_fail = 0;
  int exp_retired = 0;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic        c;
    logic [10:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: the expected EXEC strobes, derived from the opcode class.
  function automatic logic [10:0] model(input logic [5:0] op, input logic z, input logic c);
    logic inc, lpc, spc, lreg, lacc, legal, taken;
    logic [1:0] sacc;
    logic [3:0] alu;
    inc = 0; lpc = 0; spc = 0; lreg = 0; lacc = 0; sacc = 2'b00; alu = 4'b0000;
    legal = (op[5:4] == 2'b00) && (op != 6'd9) && (op != 6'd14);
    if (!legal) begin
      inc = !TRAP;
    end else if (op == 6'd15) begin
      inc = 0;
    end else if (op == 6'd6 || op == 6'd7 || op == 6'd8 || op == 6'd10) begin
      taken = (op < 6'd8) ? z : c;
      lpc = taken;
      spc = taken && (op == 6'd6 || op == 6'd8);
      inc = !taken;
    end else begin
      inc = 1;
      if (op == 6'd5) lreg = 1;
      else if (op != 6'd0) begin
        lacc = 1;
        if (op == 6'd4) sacc = 2'b01;
        else if (op == 6'd13) sacc = 2'b10;
        else if (op == 6'd1) alu = 4'b1000;
        else if (op == 6'd2) alu = 4'b1100;
        else if (op == 6'd3) alu = 4'b0100;
        else if (op == 6'd11) alu = 4'b0001;
        else alu = 4'b0011;
      end
    end
    return {inc, lpc, spc, lreg, lacc, sacc, alu};
  endfunction

  // Hold reset for 2 cycles with run=1, release it, check the IDLE cycle, and end in the first FETCH cycle.
  task automatic do_reset();
    CLB = 1; run = 1; mem_ack = 0;
    tick();
    @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_strobes", 32'(dut_word), 0);
    chk("rst_memreq", 32'(mem_req), 0);
    chk("rst_retired", 32'(retired), 0);
    chk("rst_retired2", 32'(retired2), 0);
    chk("rst_illegal", 32'(illegal), 0);
    tick();
    CLB = 0;
    @(negedge clk);
    chk("idle_after_rst", 32'(state), 0);
    chk("idle_memreq", 32'(mem_req), 0);
    tick();
    run = 0;
    exp_retired = 0;
  endtask

  // Run one instruction starting in FETCH. The ack arrives after 'delay' wait cycles.
  // Flags are inverted during EXEC to show that only the DECODE sample is used.
  task automatic do_instr(input logic [5:0] op, input int delay, input logic z, input logic c,
                          input logic [10:0] exp, input bit halt_next);
    for (int k = 0; k <= delay; k++) begin
      mem_ack = (k == delay);
      Opcode = 6'($urandom);
      Z = 1'($urandom); C = 1'($urandom);
      @(negedge clk);
      chk("fetch_state", 32'(state), 1);
      chk("fetch_memreq", 32'(mem_req), 1);
      chk("fetch_loadir", 32'(LoadIR), 32'(k == delay));
      chk("fetch_strobes", 32'(dut_word), 0);
      tick();
    end
    mem_ack = 1'($urandom); Opcode = op; Z = z; C = c;
    @(negedge clk);
    chk("decode_state", 32'(state), 2);
    chk("decode_strobes", 32'(dut_word), 0);
    chk("decode_loadir", 32'(LoadIR), 0);
    tick();
    Z = ~z; C = ~c; Opcode = 6'($urandom); mem_ack = 1'($urandom);
    @(negedge clk);
    chk("exec_state", 32'(state), 3);
    chk("exec_strobes", 32'(dut_word), 32'(exp));
    chk("exec_selalu_hi", 32'(SelALU[5:4]), 0);
    chk("exec_pc_excl", 32'(IncPC & LoadPC), 0);
    tick();
    exp_retired++;
    chk("retired", 32'(retired), 32'(exp_retired));
    $display("txn op=%b z=%0b c=%0b wait=%0d strobes=%b retired=%0d", op, z, c, delay, exp, exp_retired);
    mem_ack = 0;
    if (halt_next) begin
      @(negedge clk);
      chk("halt_state", 32'(state), 4);
      chk("halt_flag", 32'(halted), 1);
      chk("halt_strobes", 32'(dut_word), 0);
    end
  endtask

  vec_t vecs[16];
  logic [5:0] rand_ops[13] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd10, 6'd11, 6'd12, 6'd13};
  logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{6'd0,  0, 0, 11'b1_0_0_0_0_00_0000};
    vecs[1]  = '{6'd1,  1, 1, 11'b1_0_0_0_1_00_1000};
    vecs[2]  = '{6'd2,  0, 1, 11'b1_0_0_0_1_00_1100};
    vecs[3]  = '{6'd3,  1, 0, 11'b1_0_0_0_1_00_0100};
    vecs[4]  = '{6'd4,  0, 0, 11'b1_0_0_0_1_01_0000};
    vecs[5]  = '{6'd5,  1, 1, 11'b1_0_0_1_0_00_0000};
    vecs[6]  = '{6'd11, 0, 0, 11'b1_0_0_0_1_00_0001};
    vecs[7]  = '{6'd12, 1, 0, 11'b1_0_0_0_1_00_0011};
    vecs[8]  = '{6'd13, 0, 1, 11'b1_0_0_0_1_10_0000};
    vecs[9]  = '{6'd6,  1, 0, 11'b0_1_1_0_0_00_0000};
    vecs[10] = '{6'd6,  0, 1, 11'b1_0_0_0_0_00_0000};
    vecs[11] = '{6'd7,  1, 0, 11'b0_1_0_0_0_00_0000};
    vecs[12] = '{6'd8,  0, 1, 11'b0_1_1_0_0_00_0000};
    vecs[13] = '{6'd8,  1, 0, 11'b1_0_0_0_0_00_0000};
    vecs[14] = '{6'd10, 0, 1, 11'b0_1_0_0_0_00_0000};
    vecs[15] = '{6'd10, 1, 0, 11'b1_0_0_0_0_00_0000};

    // Reset, then the program ADD, LDI, HALT with an ack on every fetch cycle
    do_reset();
    do_instr(6'd1, 0, 0, 0, 11'b1_0_0_0_1_00_1000, 0);
    do_instr(6'd13, 0, 0, 0, 11'b1_0_0_0_1_10_0000, 0);
    do_instr(6'd15, 0, 0, 0, 11'b0_0_0_0_0_00_0000, 1);
    chk("prog_retired", 32'(retired), 3);
    run = 1; mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("halt_terminal", 32'(state), 4);
      chk("halt_memreq", 32'(mem_req), 0);
    end
    run = 0; mem_ack = 0;

    // JZ imm: the flag is sampled at DECODE and inverted during EXEC
    do_reset();
    do_instr(6'd7, 0, 1, 0, 11'b0_1_0_0_0_00_0000, 0);
    do_instr(6'd7, 0, 0, 1, 11'b1_0_0_0_0_00_0000, 0);

    // Fetch timeout after 15 wait cycles
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      mem_ack = 0;
      @(negedge clk);
      chk("timeout_wait", 32'(state), 1);
      tick();
    end
    @(negedge clk);
    chk("timeout_state", 32'(state), 5);
    chk("timeout_err", 32'(fetch_err), 1);
    chk("timeout_memreq", 32'(mem_req), 0);
    chk("no_timeout_inst2", 32'(state2), 1);
    run = 1; mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("err_terminal", 32'(state), 5);
    end
    run = 0; mem_ack = 0;
    // An ack on the 15th fetch cycle beats the timeout
    do_reset();
    do_instr(6'd0, 14, 0, 0, 11'b1_0_0_0_0_00_0000, 0);
    do_instr(6'd15, 0, 0, 0, 11'b0, 1);

    // Undefined opcodes: 1001, and a nonzero bit above [3:0]
    do_reset();
    do_instr(6'd9, 1, 0, 0, model(6'd9, 0, 0), TRAP);
    chk("illegal_9", 32'(illegal), 32'(TRAP));
    do_reset();
    do_instr(6'h1F, 0, 1, 1, model(6'h1F, 1, 1), TRAP);
    chk("illegal_hi", 32'(illegal), 32'(TRAP));
    do_reset();
    do_instr(6'h10, 0, 0, 0, model(6'h10, 0, 0), TRAP);
    chk("illegal_10", 32'(illegal), 32'(TRAP));

    // Table vectors
    do_reset();
    for (int i = 0; i < 16; i++)
      do_instr(vecs[i].op, i % 3, vecs[i].z, vecs[i].c, vecs[i].exp, 0);

    // Random program checked against the model
    do_reset();
    for (int i = 0; i < 40; i++) begin
      logic [5:0] op;
      logic z, c;
      op = rand_ops[$urandom_range(0, 12)];
      z = 1'($urandom); c = 1'($urandom);
      do_instr(op, $urandom_range(0, 6), z, c, model(op, z, c), 0);
    end
    do_instr(6'd15, 2, 0, 0, model(6'd15, 0, 0), 1);

    // Wrap-around of the 2-bit counter, then reset during EXEC
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_instr(6'd0, 0, 0, 0, 11'b1_0_0_0_0_00_0000, 0);
      chk("wrap_retired2", 32'(retired2), 32'(wrap_exp[i]));
    end
    mem_ack = 1;
    tick();
    mem_ack = 0; Opcode = 6'd1;
    tick();
    @(negedge clk);
    chk("pre_rst_exec", 32'(state), 3);
    CLB = 1;
    tick();
    CLB = 0;
    @(negedge clk);
    chk("exec_rst_state", 32'(state), 0);
    chk("exec_rst_retired", 32'(retired), 0);
    chk("exec_rst_retired2", 32'(retired2), 0);
    chk("exec_rst_strobes", 32'(dut_word), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
